// File: rtl/timer_countdown_if.sv
// Control strobes, BCD load values and countdown outputs between the
// timer-setting logic, the countdown core and the display/alarm driver.
interface timer_countdown_if;
    logic       tick;
    logic       load;
    logic       start;
    logic       stop;
    logic       ack;
    logic [7:0] segundosT;
    logic [7:0] minutosT;
    logic [7:0] horasT;
    logic [7:0] segundosC_out;
    logic [7:0] minutosC_out;
    logic [7:0] horasC_out;
    logic       running;
    logic       alarm;

    modport master (
        output tick, load, start, stop, ack, segundosT, minutosT, horasT,
        input  segundosC_out, minutosC_out, horasC_out, running, alarm
    );

    modport slave (
        input  tick, load, start, stop, ack, segundosT, minutosT, horasT,
        output segundosC_out, minutosC_out, horasC_out, running, alarm
    );
endinterface

// File: rtl/timer_countdown.sv
// BCD hh:mm:ss countdown with IDLE/RUN/PAUSE/DONE control and alarm output.
// Optional macro ALARM_BLINK_EN: alarm toggles on each tick while in DONE.
module timer_countdown #(
    parameter int unsigned ALARM_TICKS = 30
) (
    input  logic              clk,
    input  logic              reset,
    timer_countdown_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_sec;
    logic [7:0] r_min;
    logic [7:0] r_hour;
    logic [7:0] w_sec_nxt;
    logic [7:0] w_min_nxt;
    logic [7:0] w_hour_nxt;
    logic       r_running;
    logic       w_running_nxt;
    logic       r_alarm;
    logic       w_alarm_nxt;
    logic [7:0] r_alarm_cnt;
    logic [7:0] w_alarm_cnt_nxt;
    logic [7:0] w_alarm_cnt_inc;
    logic [7:0] w_dec_sec;
    logic [7:0] w_dec_min;
    logic [7:0] w_dec_hour;
    logic       w_dec_zero;
    logic       w_count_zero;
    logic [7:0] w_ld_sec;
    logic [7:0] w_ld_min;
    logic [7:0] w_ld_hour;

    function automatic logic [7:0] clamp_low(input logic [7:0] v);
        if (v[3:0] > 4'd9) begin
            return {v[7:4], 4'd9};
        end else begin
            return v;
        end
    endfunction

    function automatic logic [7:0] sanitize_ms(input logic [7:0] v);
        if (v[7:4] > 4'd5) begin
            return 8'h59;
        end else begin
            return clamp_low(v);
        end
    endfunction

    function automatic logic [7:0] sanitize_hr(input logic [7:0] v);
        logic [7:0] t;
        t = clamp_low(v);
        if (t > 8'h23) begin
            return 8'h23;
        end else begin
            return t;
        end
    endfunction

    // 00 wraps to 59 so the caller can borrow from the next field up.
    function automatic logic [7:0] bcd_dec_wrap(input logic [7:0] v);
        if (v == 8'h00) begin
            return 8'h59;
        end else if (v[3:0] == 4'd0) begin
            return {v[7:4] - 4'd1, 4'd9};
        end else begin
            return {v[7:4], v[3:0] - 4'd1};
        end
    endfunction

    assign w_ld_sec     = sanitize_ms(bus.segundosT);
    assign w_ld_min     = sanitize_ms(bus.minutosT);
    assign w_ld_hour    = sanitize_hr(bus.horasT);
    assign w_count_zero = (r_sec == 8'h00) && (r_min == 8'h00) && (r_hour == 8'h00);

    assign w_dec_sec  = bcd_dec_wrap(r_sec);
    assign w_dec_min  = (r_sec == 8'h00) ? bcd_dec_wrap(r_min) : r_min;
    assign w_dec_hour = ((r_sec == 8'h00) && (r_min == 8'h00)) ? bcd_dec_wrap(r_hour) : r_hour;
    assign w_dec_zero = (w_dec_sec == 8'h00) && (w_dec_min == 8'h00) && (w_dec_hour == 8'h00);

    assign w_alarm_cnt_inc = r_alarm_cnt + 8'd1;

    // Next-state and next-count selection.
    always_comb begin
        w_state_nxt     = r_state;
        w_sec_nxt       = r_sec;
        w_min_nxt       = r_min;
        w_hour_nxt      = r_hour;
        w_alarm_cnt_nxt = r_alarm_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.load) begin
                    w_sec_nxt  = w_ld_sec;
                    w_min_nxt  = w_ld_min;
                    w_hour_nxt = w_ld_hour;
                end else if (bus.start && !w_count_zero) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.tick) begin
                    w_sec_nxt  = w_dec_sec;
                    w_min_nxt  = w_dec_min;
                    w_hour_nxt = w_dec_hour;
                end else begin
                    w_sec_nxt  = r_sec;
                end
                // Reaching zero wins over stop so a paused timer is never at 00:00:00.
                if (bus.tick && w_dec_zero) begin
                    w_state_nxt = ST_DONE;
                end else if (bus.stop) begin
                    w_state_nxt = ST_PAUSE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (bus.load) begin
                    w_sec_nxt   = w_ld_sec;
                    w_min_nxt   = w_ld_min;
                    w_hour_nxt  = w_ld_hour;
                    w_state_nxt = ST_IDLE;
                end else if (bus.start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (bus.ack) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.load) begin
                    w_sec_nxt   = w_ld_sec;
                    w_min_nxt   = w_ld_min;
                    w_hour_nxt  = w_ld_hour;
                    w_state_nxt = ST_IDLE;
                end else if (bus.tick && (ALARM_TICKS != 32'd0)) begin
                    w_alarm_cnt_nxt = w_alarm_cnt_inc;
                    if (w_alarm_cnt_inc == ALARM_TICKS[7:0]) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered status outputs derived from the state being entered.
    always_comb begin
        w_running_nxt = (w_state_nxt == ST_RUN);
        w_alarm_nxt   = 1'b0;
        if (w_state_nxt != ST_DONE) begin
            w_alarm_nxt = 1'b0;
        end else if (r_state != ST_DONE) begin
            w_alarm_nxt = 1'b1;
        end else begin
`ifdef ALARM_BLINK_EN
            if (bus.tick) begin
                w_alarm_nxt = ~r_alarm;
            end else begin
                w_alarm_nxt = r_alarm;
            end
`else
            w_alarm_nxt = 1'b1;
`endif
        end
    end

    // State, count and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sec       <= 8'h00;
            r_min       <= 8'h00;
            r_hour      <= 8'h00;
            r_running   <= 1'b0;
            r_alarm     <= 1'b0;
            r_alarm_cnt <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_sec     <= w_sec_nxt;
            r_min     <= w_min_nxt;
            r_hour    <= w_hour_nxt;
            r_running <= w_running_nxt;
            r_alarm   <= w_alarm_nxt;
            if (w_state_nxt == ST_DONE && r_state == ST_DONE) begin
                r_alarm_cnt <= w_alarm_cnt_nxt;
            end else begin
                r_alarm_cnt <= 8'd0;
            end
        end
    end

    assign bus.segundosC_out = r_sec;
    assign bus.minutosC_out  = r_min;
    assign bus.horasC_out    = r_hour;
    assign bus.running       = r_running;
    assign bus.alarm         = r_alarm;

endmodule

// File: tb/tb_timer_countdown.sv
// Scoreboard bench for timer_countdown built with ALARM_TICKS=3; follows
// ALARM_BLINK_EN when the design is built with it.
module tb_timer_countdown;

    logic clk = 1'b0;
    logic reset;

    timer_countdown_if tb_if ();

    timer_countdown #(.ALARM_TICKS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tb_if.slave)
    );

    always #5 clk = ~clk;

`ifdef ALARM_BLINK_EN
    localparam logic BLINK = 1'b1;
`else
    localparam logic BLINK = 1'b0;
`endif

    localparam logic [4:0] N = 5'b00000;
    localparam logic [4:0] T = 5'b10000;
    localparam logic [4:0] L = 5'b01000;
    localparam logic [4:0] S = 5'b00100;
    localparam logic [4:0] P = 5'b00010;
    localparam logic [4:0] A = 5'b00001;

    typedef struct {
        string      tag;
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic       run;
        logic       alm;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("sb_underflow", 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            check_val({e.tag, ".hh"}, tb_if.horasC_out, e.h);
            check_val({e.tag, ".mm"}, tb_if.minutosC_out, e.m);
            check_val({e.tag, ".ss"}, tb_if.segundosC_out, e.s);
            check_val({e.tag, ".running"}, {7'd0, tb_if.running}, {7'd0, e.run});
            check_val({e.tag, ".alarm"}, {7'd0, tb_if.alarm}, {7'd0, e.alm});
        end
    endtask

    // strb = {tick, load, start, stop, ack}; expected outputs are queued before the edge.
    task automatic step(input string tag, input logic [4:0] strb,
                        input logic [7:0] hi, input logic [7:0] mi, input logic [7:0] si,
                        input logic [7:0] he, input logic [7:0] me, input logic [7:0] se,
                        input logic run, input logic alm);
        exp_t e;
        e.tag = tag; e.h = he; e.m = me; e.s = se; e.run = run; e.alm = alm;
        sb.push_back(e);
        tb_if.tick      = strb[4];
        tb_if.load      = strb[3];
        tb_if.start     = strb[2];
        tb_if.stop      = strb[1];
        tb_if.ack       = strb[0];
        tb_if.horasT    = hi;
        tb_if.minutosT  = mi;
        tb_if.segundosT = si;
        @(posedge clk);
        #1;
        tb_if.tick  = 1'b0;
        tb_if.load  = 1'b0;
        tb_if.start = 1'b0;
        tb_if.stop  = 1'b0;
        tb_if.ack   = 1'b0;
        pop_check();
    endtask

    initial begin
        reset = 1'b1;
        tb_if.tick = 1'b0; tb_if.load = 1'b0; tb_if.start = 1'b0;
        tb_if.stop = 1'b0; tb_if.ack = 1'b0;
        tb_if.horasT = 8'h00; tb_if.minutosT = 8'h00; tb_if.segundosT = 8'h00;
        step("reset", N, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;

        // One minute down to zero, then acknowledge.
        step("load_1m", L, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0);
        step("start_1m", S, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0);
        step("tick_1m", T, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h59, 1'b1, 1'b0);
        for (int i = 1; i <= 59; i++) begin
            step("count_1m", T, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, to_bcd(59 - i),
                 (59 - i) != 0, (59 - i) == 0);
        end
        step("ack", A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // Double borrow, pause, sanitised load from PAUSE.
        step("load_1h", L, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
        step("start_1h", S, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
        step("borrow2", T, 8'h00, 8'h00, 8'h00, 8'h00, 8'h59, 8'h59, 1'b1, 1'b0);
        step("stop", P, 8'h00, 8'h00, 8'h00, 8'h00, 8'h59, 8'h59, 1'b0, 1'b0);
        step("sanitize1", L, 8'h31, 8'h3F, 8'h7A, 8'h23, 8'h39, 8'h59, 1'b0, 1'b0);

        // start+stop+tick together: decrement then pause; ticks frozen.
        step("load_10s", L, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h10, 1'b0, 1'b0);
        step("start_10s", S, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 1'b1, 1'b0);
        step("tsp_same", T | S | P, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h09, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("pause_frozen", T, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h09, 1'b0, 1'b0);
        end
        step("resume", S, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h09, 1'b1, 1'b0);
        step("resume_tick", T, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 1'b1, 1'b0);
        step("stop2", P, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 1'b0, 1'b0);

        // Zero count cannot start; short run into DONE and timeout.
        step("load_zero", L, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step("start_zero", S, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step("load_2s", L, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h02, 1'b0, 1'b0);
        step("start_2s", S, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0);
        step("tick_2s_a", T, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
        step("done_entry", T, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        step("done_idle", N, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        step("done_start", S | P, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        step("done_tick1", T, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, ~BLINK);
        step("done_tick2", T, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        step("done_tick3", T, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        step("idle_after", S, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // Second sanitise pattern, load ignored in RUN, reset mid-run.
        step("sanitize2", L, 8'h2F, 8'h60, 8'h1C, 8'h23, 8'h59, 8'h19, 1'b0, 1'b0);
        step("start_big", S, 8'h00, 8'h00, 8'h00, 8'h23, 8'h59, 8'h19, 1'b1, 1'b0);
        step("tick_big", T, 8'h00, 8'h00, 8'h00, 8'h23, 8'h59, 8'h18, 1'b1, 1'b0);
        step("run_load", L, 8'h01, 8'h02, 8'h03, 8'h23, 8'h59, 8'h18, 1'b1, 1'b0);
        reset = 1'b1;
        step("reset_mid", T, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        step("post_reset", T, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
